// File: rtl/ntr_rx_pkg.sv
// Shared constants for the NTR command-phase receiver.
//
// Contents:
//   NTR_CMD_BYTES  bytes per command phase
//   NTR_CMD_W      width of the assembled command
//   NTR_BYTE_W     width of the card data bus
//   NTR_CNT_W      width of the byte counter (wraps modulo NTR_CMD_BYTES)
//   NTR_DEB_CNT_W  width of the debounce disagreement counter (CYCLES up to 15)
package ntr_rx_pkg;

    localparam int unsigned NTR_CMD_BYTES = 8;
    localparam int unsigned NTR_CMD_W     = 64;
    localparam int unsigned NTR_BYTE_W    = 8;
    localparam int unsigned NTR_CNT_W     = $clog2(NTR_CMD_BYTES);
    localparam int unsigned NTR_DEB_CNT_W = 4;

endpackage

// File: rtl/debouncer.sv
// Single-bit debouncer: the output follows the input only after CYCLES
// consecutive samples disagree with the current output. Any agreeing sample
// restarts the count, so pulses shorter than CYCLES clocks are swallowed.
//
// Parameters:
//   INIT    reset value of the output
//   CYCLES  consecutive disagreeing samples needed to change (1..15)
// Ports:
//   clk_i   clock
//   rst_i   synchronous active-high reset
//   in_i    already-synchronized input
//   out_o   debounced output (registered)
module debouncer
    import ntr_rx_pkg::*;
#(
    parameter bit          INIT   = 1'b0,
    parameter int unsigned CYCLES = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic in_i,
    output logic out_o
);

    if (CYCLES < 1 || CYCLES > 15) begin : g_bad_cycles
        $error("debouncer: CYCLES must be in 1..15");
    end

    localparam logic [NTR_DEB_CNT_W-1:0] LastCnt = NTR_DEB_CNT_W'(CYCLES - 1);

    logic                     out_q;
    logic [NTR_DEB_CNT_W-1:0] cnt_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            out_q <= INIT;
            cnt_q <= '0;
        end else if (in_i == out_q) begin
            cnt_q <= '0;
        end else if (cnt_q == LastCnt) begin
            // This sample is the CYCLES-th disagreeing one in a row.
            out_q <= in_i;
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign out_o = out_q;

endmodule

// File: rtl/ntr_debounce_rx.sv
// NTR (DS card bus) command-phase receiver. Synchronizes the card pins into
// clk_i, optionally debounces the card clock, and shifts in one byte per
// rising edge of that clock while chip select is low, flagging a complete
// 8-byte command.
//
// Build option: define NTR_RX_DEBOUNCE_EN to insert the debouncer on the
// synchronized card clock. Without it the edge detector runs directly on the
// synchronized clock and DEBOUNCE_INIT / DEBOUNCE_CYCLES are unused.
//
// Ports:
//   clk_i       system clock (single domain)
//   rst_i       synchronous active-high reset
//   ntr_clk_i   card bus clock, asynchronous, may bounce
//   ntr_cs1_i   chip select, active low
//   ntr_data_i  card bus data byte
//   command_o   assembled command, first byte in [63:56]
//   ready_o     all 8 bytes received in the current select window
//   count_o     bytes received in the window, modulo 8
module ntr_debounce_rx
    import ntr_rx_pkg::*;
#(
    parameter bit          DEBOUNCE_INIT   = 1'b0,
    parameter int unsigned DEBOUNCE_CYCLES = 2,
    parameter int unsigned SYNC_STAGES     = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  ntr_clk_i,
    input  logic                  ntr_cs1_i,
    input  logic [NTR_BYTE_W-1:0] ntr_data_i,
    output logic [NTR_CMD_W-1:0]  command_o,
    output logic                  ready_o,
    output logic [NTR_CNT_W-1:0]  count_o
);

    if (SYNC_STAGES < 2) begin : g_bad_sync
        $error("ntr_debounce_rx: SYNC_STAGES must be at least 2");
    end

    // ------------------------------------------------------------------
    // Pin synchronizers. Chip select resets high so the block starts out
    // deselected.
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0]                 clk_sync_q;
    logic [SYNC_STAGES-1:0]                 cs_sync_q;
    logic [SYNC_STAGES-1:0][NTR_BYTE_W-1:0] data_sync_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            clk_sync_q  <= '0;
            cs_sync_q   <= '1;
            data_sync_q <= '0;
        end else begin
            clk_sync_q  <= {clk_sync_q[SYNC_STAGES-2:0], ntr_clk_i};
            cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], ntr_cs1_i};
            data_sync_q <= {data_sync_q[SYNC_STAGES-2:0], ntr_data_i};
        end
    end

    logic                  clk_sync;
    logic                  cs_sync;
    logic [NTR_BYTE_W-1:0] data_sync;

    assign clk_sync  = clk_sync_q[SYNC_STAGES-1];
    assign cs_sync   = cs_sync_q[SYNC_STAGES-1];
    assign data_sync = data_sync_q[SYNC_STAGES-1];

    // ------------------------------------------------------------------
    // Card clock conditioning
    // ------------------------------------------------------------------
    logic clk_deb;

`ifdef NTR_RX_DEBOUNCE_EN
    localparam bit EdgeInit = DEBOUNCE_INIT;

    debouncer #(
        .INIT   (DEBOUNCE_INIT),
        .CYCLES (DEBOUNCE_CYCLES)
    ) u_debouncer (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .in_i  (clk_sync),
        .out_o (clk_deb)
    );
`else
    localparam bit EdgeInit = 1'b0;

    assign clk_deb = clk_sync;

    logic unused_cfg;
    assign unused_cfg = ^{DEBOUNCE_INIT, DEBOUNCE_CYCLES};
`endif

    // Previous value resets to the conditioned clock's own reset value so
    // reset never manufactures an edge.
    logic clk_prev_q;
    logic clk_rise;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            clk_prev_q <= EdgeInit;
        end else begin
            clk_prev_q <= clk_deb;
        end
    end

    assign clk_rise = clk_deb & ~clk_prev_q;

    // ------------------------------------------------------------------
    // Byte shifter
    // ------------------------------------------------------------------
    localparam logic [NTR_CNT_W-1:0] LastByte = NTR_CNT_W'(NTR_CMD_BYTES - 1);

    logic [NTR_CMD_W-1:0] cmd_q, cmd_d;
    logic [NTR_CNT_W-1:0] cnt_q, cnt_d;
    logic                 rdy_q, rdy_d;

    always_comb begin
        cmd_d = cmd_q;
        cnt_d = cnt_q;
        rdy_d = rdy_q;
        if (cs_sync) begin
            // Deselect wins over a coincident edge; command is left as-is.
            cnt_d = '0;
            rdy_d = 1'b0;
        end else if (clk_rise && !rdy_q) begin
            cmd_d = {cmd_q[NTR_CMD_W-NTR_BYTE_W-1:0], data_sync};
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == LastByte) begin
                rdy_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cmd_q <= '0;
            cnt_q <= '0;
            rdy_q <= 1'b0;
        end else begin
            cmd_q <= cmd_d;
            cnt_q <= cnt_d;
            rdy_q <= rdy_d;
        end
    end

    assign command_o = cmd_q;
    assign ready_o   = rdy_q;
    assign count_o   = cnt_q;

endmodule

// File: tb/tb_ntr_debounce_rx.sv
// Directed self-checking bench for ntr_debounce_rx with default parameters.
// Expectations that depend on the debounce build option are chosen with the
// same macro the design uses.
module tb_ntr_debounce_rx;

`ifdef NTR_RX_DEBOUNCE_EN
    localparam int Lat       = 5;  // SYNC_STAGES + DEBOUNCE_CYCLES + 1
    localparam int GlitchCnt = 1;  // glitch swallowed
    localparam logic [63:0] PartialCmd = 64'h00FF_1110_1112_1314;
`else
    localparam int Lat       = 3;  // SYNC_STAGES + 1
    localparam int GlitchCnt = 2;  // glitch counts as an edge
    localparam logic [63:0] PartialCmd = 64'hFF11_2210_1112_1314;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        ntr_clk;
    logic        ntr_cs1;
    logic [7:0]  ntr_data;
    logic [63:0] command;
    logic        ready;
    logic [2:0]  count;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    ntr_debounce_rx #(
        .DEBOUNCE_INIT   (1'b0),
        .DEBOUNCE_CYCLES (2),
        .SYNC_STAGES     (2)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .ntr_clk_i  (ntr_clk),
        .ntr_cs1_i  (ntr_cs1),
        .ntr_data_i (ntr_data),
        .command_o  (command),
        .ready_o    (ready),
        .count_o    (count)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    // Inputs change and outputs are sampled on the falling edge.
    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b);
        ntr_data = b;
        ntr_clk  = 1'b0;
        wait_clks(4);
        ntr_clk  = 1'b1;
        wait_clks(8);
        ntr_clk  = 1'b0;
        wait_clks(2);
    endtask

    task automatic send_cmd(input string tag, input logic [63:0] cmd);
        for (int i = 0; i < 8; i++) begin
            send_byte(cmd[63-8*i -: 8]);
            check_eq($sformatf("%s_cnt%0d", tag, i), {61'd0, count}, 64'((i + 1) % 8));
            check_eq($sformatf("%s_rdy%0d", tag, i), {63'd0, ready}, {63'd0, i == 7});
        end
        check_eq($sformatf("%s_cmd", tag), command, cmd);
    endtask

    initial begin
        rst      = 1'b1;
        ntr_clk  = 1'b0;
        ntr_cs1  = 1'b1;
        ntr_data = 8'h00;
        wait_clks(3);
        check_eq("rst_cmd", command, 64'd0);
        check_eq("rst_rdy", {63'd0, ready}, 64'd0);
        check_eq("rst_cnt", {61'd0, count}, 64'd0);
        rst = 1'b0;

        // Idle: clock toggles while deselected, nothing moves.
        for (int i = 0; i < 3; i++) begin
            send_byte(8'h5A);
            check_eq("idle_cmd", command, 64'd0);
            check_eq("idle_rdy", {63'd0, ready}, 64'd0);
            check_eq("idle_cnt", {61'd0, count}, 64'd0);
        end

        // First command, first byte with exact latency check.
        ntr_cs1 = 1'b0;
        wait_clks(4);
        ntr_data = 8'hFF;
        wait_clks(4);
        ntr_clk = 1'b1;
        wait_clks(Lat - 1);
        check_eq("lat_before", {61'd0, count}, 64'd0);
        wait_clks(1);
        check_eq("lat_cnt", {61'd0, count}, 64'd1);
        check_eq("lat_cmd", command, 64'h0000_0000_0000_00FF);
        wait_clks(8 - Lat);
        ntr_clk = 1'b0;
        wait_clks(2);
        for (int i = 1; i < 8; i++) begin
            send_byte((i == 7) ? 8'hFF : 8'h00);
            check_eq($sformatf("c1_cnt%0d", i), {61'd0, count}, 64'((i + 1) % 8));
            check_eq($sformatf("c1_rdy%0d", i), {63'd0, ready}, {63'd0, i == 7});
        end
        check_eq("c1_cmd", command, 64'hFF00_0000_0000_00FF);
        check_eq("c1_bit56", {63'd0, command[56]}, 64'd1);

        // Data-phase edges after ready are ignored.
        for (int i = 0; i < 3; i++) send_byte(8'hAA);
        check_eq("frz_cmd", command, 64'hFF00_0000_0000_00FF);
        check_eq("frz_cnt", {61'd0, count}, 64'd0);
        check_eq("frz_rdy", {63'd0, ready}, 64'd1);

        // Deselect: ready falls 3 clocks later.
        ntr_cs1 = 1'b1;
        wait_clks(2);
        check_eq("desel_rdy_hold", {63'd0, ready}, 64'd1);
        wait_clks(1);
        check_eq("desel_rdy", {63'd0, ready}, 64'd0);
        check_eq("desel_cnt", {61'd0, count}, 64'd0);
        check_eq("desel_cmd", command, 64'hFF00_0000_0000_00FF);

        // One-clock glitch on the card clock between bytes.
        ntr_cs1 = 1'b0;
        wait_clks(4);
        send_byte(8'h11);
        check_eq("glt_pre", {61'd0, count}, 64'd1);
        ntr_data = 8'h22;
        wait_clks(2);
        ntr_clk = 1'b1;
        wait_clks(1);
        ntr_clk = 1'b0;
        wait_clks(8);
        check_eq("glt_cnt", {61'd0, count}, 64'(GlitchCnt));
        ntr_cs1 = 1'b1;
        wait_clks(4);

        // Partial command abandoned by deselect.
        ntr_cs1 = 1'b0;
        wait_clks(4);
        for (int i = 0; i < 5; i++) begin
            send_byte(8'h10 + 8'(i));
            check_eq($sformatf("part_rdy%0d", i), {63'd0, ready}, 64'd0);
            check_eq($sformatf("part_cnt%0d", i), {61'd0, count}, 64'(i + 1));
        end
        ntr_cs1 = 1'b1;
        wait_clks(4);
        check_eq("part_end_rdy", {63'd0, ready}, 64'd0);
        check_eq("part_end_cnt", {61'd0, count}, 64'd0);
        check_eq("part_end_cmd", command, PartialCmd);

        ntr_cs1 = 1'b0;
        wait_clks(4);
        send_cmd("c2", 64'h0123_4567_89AB_CDEF);
        ntr_cs1 = 1'b1;
        wait_clks(4);

        // Reset in the middle of a command.
        ntr_cs1 = 1'b0;
        wait_clks(4);
        for (int i = 0; i < 4; i++) send_byte(8'hA1 + 8'(i));
        check_eq("mid_cnt", {61'd0, count}, 64'd4);
        rst = 1'b1;
        wait_clks(1);
        check_eq("mrst_cmd", command, 64'd0);
        check_eq("mrst_cnt", {61'd0, count}, 64'd0);
        check_eq("mrst_rdy", {63'd0, ready}, 64'd0);
        rst = 1'b0;
        wait_clks(4);
        send_cmd("c3", 64'hDEAD_BEEF_CAFE_F00D);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
